// File: rtl/pe_stream_tx.sv
// Stream transmitter for the PE array input port: holds filter and feature buffers and
// streams filter beats, then one or more passes of feature beats, over a valid/ready link.
module pe_stream_tx #(
    parameter int DATA_W     = 32,
    parameter int FEAT_DEPTH = 64,
    parameter int FILT_DEPTH = 4,
    parameter int LANES      = 4,
    localparam int AW        = $clog2(FEAT_DEPTH),
    localparam int BEAT_W    = LANES * DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [7:0]        repeat_cnt,
    output logic              ovalid,
    input  logic              oready,
    output logic [BEAT_W-1:0] odata,
    output logic              ofilt,
    output logic              olast,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    // state | meaning
    // IDLE  | waiting for start, buffers writable
    // FILT  | presenting filter beats
    // FEAT  | presenting feature beats, pass_left passes remaining incl. current
    // DONE  | one-cycle done pulse after the final handshake

    localparam int FW         = (FILT_DEPTH > 1) ? $clog2(FILT_DEPTH) : 1;
    localparam int FILT_BEATS = FILT_DEPTH / LANES;
    localparam int FEAT_BEATS = FEAT_DEPTH / LANES;
    localparam logic [AW-1:0] FILT_END = AW'(FILT_BEATS - 1);
    localparam logic [AW-1:0] FEAT_END = AW'(FEAT_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILT, S_FEAT, S_DONE} state_t;

    state_t            state;
    logic [AW-1:0]     beat_idx;
    logic [AW-1:0]     nidx;
    logic [7:0]        pass_left;
    logic              wr_ok;
    logic              fire;
    logic [DATA_W-1:0] feat_mem [FEAT_DEPTH];
    logic [DATA_W-1:0] filt_mem [FILT_DEPTH];

    assign wr_ok = wr_en && !busy && !(wr_sel && ({1'b0, wr_addr} >= (AW+1)'(FILT_DEPTH)));
    assign fire  = ovalid && oready;
    assign nidx  = beat_idx + AW'(1);

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            if (wr_sel) filt_mem[wr_addr[FW-1:0]] <= wr_data;
            else        feat_mem[wr_addr]         <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 wr_err <= 1'b0;
        else if (wr_en && !wr_ok)  wr_err <= 1'b1;
    end

    // Same-cycle write bypass lets a start alongside a legal write see the new word.
    function automatic logic [BEAT_W-1:0] read_beat(input logic sel, input logic [AW-1:0] idx);
        logic [BEAT_W-1:0] b;
        logic [AW-1:0]     a;
        b = '0;
        for (int k = 0; k < LANES; k++) begin
            a = AW'(int'(idx) * LANES + k);
            if (wr_ok && (wr_sel == sel) && (wr_addr == a))
                b[k*DATA_W +: DATA_W] = wr_data;
            else if (sel)
                b[k*DATA_W +: DATA_W] = filt_mem[a[FW-1:0]];
            else
                b[k*DATA_W +: DATA_W] = feat_mem[a];
        end
        return b;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ovalid    <= 1'b0;
            odata     <= '0;
            ofilt     <= 1'b0;
            olast     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            beat_idx  <= '0;
            pass_left <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FILT;
                        pass_left <= (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
                        busy      <= 1'b1;
                        ovalid    <= 1'b1;
                        ofilt     <= 1'b1;
                        olast     <= 1'b0;
                        beat_idx  <= '0;
                        odata     <= read_beat(1'b1, '0);
                    end
                end
                S_FILT: begin
                    if (fire) begin
                        if (beat_idx == FILT_END) begin
                            state    <= S_FEAT;
                            beat_idx <= '0;
                            ofilt    <= 1'b0;
                            odata    <= read_beat(1'b0, '0);
                            olast    <= (pass_left == 8'd1) && (FEAT_BEATS == 1);
                        end else begin
                            beat_idx <= nidx;
                            odata    <= read_beat(1'b1, nidx);
                        end
                    end
                end
                S_FEAT: begin
                    if (fire) begin
                        if (olast) begin
                            state     <= S_DONE;
                            ovalid    <= 1'b0;
                            olast     <= 1'b0;
                            done      <= 1'b1;
                            pass_left <= pass_left - 8'd1;
                        end else if (beat_idx == FEAT_END) begin
                            beat_idx  <= '0;
                            pass_left <= pass_left - 8'd1;
                            odata     <= read_beat(1'b0, '0);
                            olast     <= (pass_left == 8'd2) && (FEAT_BEATS == 1);
                        end else begin
                            beat_idx <= nidx;
                            odata    <= read_beat(1'b0, nidx);
                            olast    <= (pass_left == 8'd1) && (nidx == FEAT_END);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_stream_tx.sv
// Bench for pe_stream_tx: a queue-based model of the expected beat stream, checked every cycle.
module tb_pe_stream_tx;

    localparam int BW = 128;

    typedef struct packed {
        logic [BW-1:0] data;
        logic          filt;
        logic          last;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [5:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          start = 1'b0;
    logic [7:0]    repeat_cnt = '0;
    logic          ovalid;
    logic          oready = 1'b1;
    logic [BW-1:0] odata;
    logic          ofilt;
    logic          olast;
    logic          busy;
    logic          done;
    logic          wr_err;

    pe_stream_tx dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .repeat_cnt(repeat_cnt), .ovalid(ovalid),
        .oready(oready), .odata(odata), .ofilt(ofilt), .olast(olast), .busy(busy),
        .done(done), .wr_err(wr_err)
    );

    always #5 clock = ~clock;

    logic [31:0] m_feat [64];
    logic [31:0] m_filt [4];
    logic        m_err = 1'b0;
    beat_t       exp_q [$];
    logic        active = 1'b0;
    logic        done_due = 1'b0;
    int          pop_n = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          mode = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] beat_of(input logic sel, input int idx);
        logic [BW-1:0] b;
        for (int k = 0; k < 4; k++)
            b[k*32 +: 32] = sel ? m_filt[idx*4 + k] : m_feat[idx*4 + k];
        return b;
    endfunction

    task automatic build_queue(input logic [7:0] rc);
        int passes;
        beat_t b;
        passes = (rc == 8'd0) ? 1 : int'(rc);
        exp_q.delete();
        b.filt = 1'b1; b.last = 1'b0; b.data = beat_of(1'b1, 0);
        exp_q.push_back(b);
        for (int p = 0; p < passes; p++)
            for (int j = 0; j < 16; j++) begin
                b.filt = 1'b0;
                b.last = (p == passes - 1) && (j == 15);
                b.data = beat_of(1'b0, j);
                exp_q.push_back(b);
            end
    endtask

    // One bus cycle of host activity; the model follows the write/start rules afterwards.
    task automatic step(input logic we, input logic sel, input logic [5:0] addr,
                        input logic [31:0] data, input logic st, input logic [7:0] rc);
        logic mb;
        @(posedge clock); #1;
        wr_en = we; wr_sel = sel; wr_addr = addr; wr_data = data; start = st; repeat_cnt = rc;
        mb = active || done_due;
        @(posedge clock); #1;
        wr_en = 1'b0; start = 1'b0;
        if (we) begin
            if (mb || (sel && addr >= 6'd4)) m_err = 1'b1;
            else if (sel) m_filt[addr[1:0]] = data;
            else m_feat[addr] = data;
        end
        if (st && !mb) begin
            build_queue(rc);
            active = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active || done_due) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        if (active || done_due) begin
            chk("wait_idle_timeout", 128'(1), 128'(0));
            active = 1'b0; done_due = 1'b0; exp_q.delete();
        end
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (pop_n < target && n < 1000) begin
            @(posedge clock);
            n++;
        end
        if (pop_n < target) chk("wait_pops_timeout", 128'(pop_n), 128'(target));
    endtask

    initial begin
        forever begin
            int pat = 0;
            @(posedge clock); #1;
            case (mode)
                0: oready = 1'b1;
                1: begin oready = (pat == 0); pat = (pat + 1) % 3; end
                default: oready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("wr_err", 128'(wr_err), 128'(m_err));
            if (active) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underrun", 128'(1), 128'(0));
                    active = 1'b0;
                end else begin
                    chk("beat_status", 128'({ovalid, busy, done, ofilt, olast}),
                        128'({3'b110, exp_q[0].filt, exp_q[0].last}));
                    chk("beat_data", odata, exp_q[0].data);
                    if (oready) begin
                        void'(exp_q.pop_front());
                        pop_n++;
                        if (exp_q.size() == 0) begin
                            active = 1'b0;
                            done_due = 1'b1;
                        end
                    end
                end
            end else if (done_due) begin
                chk("done_pulse", 128'({ovalid, busy, done}), 128'(3'b011));
                done_due = 1'b0;
            end else begin
                chk("idle_status", 128'({ovalid, busy, done}), 128'(3'b000));
            end
        end
    end

    initial begin
        int base;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 128'({ovalid, busy, done, ofilt, olast, wr_err}), 128'(0));
        chk("reset_odata", odata, '0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 6'(i), 32'(i), 1'b0, 8'd0);
        for (int j = 0; j < 4; j++) step(1'b1, 1'b1, 6'(j), 32'(100 + j), 1'b0, 8'd0);

        // Basic stream with oready held high
        mode = 0;
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd1);
        chk("pin_len17", 128'(exp_q.size()), 128'(17));
        chk("pin_beat0", exp_q[0].data, {32'd103, 32'd102, 32'd101, 32'd100});
        chk("pin_beat1", exp_q[1].data, {32'd3, 32'd2, 32'd1, 32'd0});
        chk("pin_beat16", exp_q[16].data, {32'd63, 32'd62, 32'd61, 32'd60});
        chk("pin_last16", 128'({exp_q[16].last, exp_q[15].last, exp_q[0].filt}), 128'(3'b101));
        wait_idle();

        // Stalling pattern 1,0,0
        mode = 1;
        base = pop_n;
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd1);
        wait_idle();
        chk("stall_count", 128'(pop_n - base), 128'(17));

        // Multiple passes and repeat_cnt=0
        mode = 0;
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd3);
        chk("pin_len49", 128'(exp_q.size()), 128'(49));
        chk("pin_wrap", exp_q[17].data, {32'd3, 32'd2, 32'd1, 32'd0});
        chk("pin_last48", 128'({exp_q[48].last, exp_q[16].last, exp_q[32].last}), 128'(3'b100));
        wait_idle();
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd0);
        chk("pin_rc0_len", 128'(exp_q.size()), 128'(17));
        wait_idle();

        // Illegal writes
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd1);
        step(1'b1, 1'b0, 6'd5, 32'd999, 1'b0, 8'd0);
        chk("wr_err_busy", 128'(wr_err), 128'(1));
        wait_idle();
        step(1'b1, 1'b1, 6'd5, 32'd555, 1'b0, 8'd0);
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd1);
        chk("pin_feat5_kept", 128'(exp_q[2].data[63:32]), 128'(5));
        wait_idle();

        // start while busy is ignored
        base = pop_n;
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd1);
        wait_pops(base + 3);
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd3);
        wait_idle();
        chk("start_ignored_count", 128'(pop_n - base), 128'(17));

        // Reset while feature beat 7 is presented
        mode = 2;
        base = pop_n;
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd1);
        wait_pops(base + 8);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_abort", 128'({ovalid, busy, done, wr_err}), 128'(0));
        exp_q.delete(); active = 1'b0; done_due = 1'b0; m_err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        mode = 0;
        base = pop_n;
        step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'd1);
        wait_idle();
        chk("replay_count", 128'(pop_n - base), 128'(17));

        // Write and start in the same cycle
        step(1'b1, 1'b0, 6'd0, 32'd77, 1'b1, 8'd1);
        chk("pin_same_cycle_write", 128'(exp_q[1].data[31:0]), 128'(77));
        wait_idle();

        // Randomised data, writes, repeat counts and backpressure
        for (int it = 0; it < 6; it++) begin
            mode = it % 3;
            for (int w = 0; w < 6; w++) begin
                logic s;
                s = 1'($urandom_range(0, 1));
                step(1'b1, s, s ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63)),
                     $urandom, 1'b0, 8'd0);
            end
            step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 8'($urandom_range(0, 3)));
            wait_idle();
        end

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
